// File: rtl/iigs_pkg.sv
//------------------------------------------------------------------------------
// Module : iigs_pkg
// Brief  : Shared bank constants, shadow-entry type and arbiter enums for the
//          slow-RAM path.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package iigs_pkg;

    localparam logic [7:0]  BANK_00   = 8'h00;
    localparam logic [7:0]  BANK_01   = 8'h01;
    localparam logic [7:0]  BANK_E0   = 8'hE0;
    localparam logic [7:0]  BANK_E1   = 8'hE1;
    localparam logic [15:0] SHADOW_LO = 16'h0400;
    localparam logic [15:0] SHADOW_HI = 16'hBFFF;

    typedef struct packed {
        logic        a16;
        logic [15:0] addr;
        logic [7:0]  data;
    } shadow_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_FIFO = 2'd2,
        GNT_CPU  = 2'd3
    } arb_grant_t;

    function automatic logic is_direct(input logic [7:0] bank);
        return (bank == BANK_E0) || (bank == BANK_E1);
    endfunction

    function automatic logic is_shadow(input logic we, input logic [7:0] bank,
                                       input logic [15:0] addr, input logic en);
        return we && en && ((bank == BANK_00) || (bank == BANK_01)) &&
               (addr >= SHADOW_LO) && (addr <= SHADOW_HI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module : sync_fifo
// Brief  : Power-of-two synchronous FIFO with full/empty flags; a push into a
//          full FIFO is accepted when a pop happens in the same cycle.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int               c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/slowram_arbiter.sv
//------------------------------------------------------------------------------
// Module : slowram_arbiter
// Brief  : Shares the 1MHz E0/E1 slow RAM between video fetch, direct CPU
//          access and buffered 00/01 shadow writes, one access per slot.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module slowram_arbiter
    import iigs_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SLOT_DIV   = 14
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_bank,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        shadow_en,
    output logic        cpu_stall,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        vid_req,
    input  logic [16:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_data,
    output logic        ram_ce,
    output logic        ram_wr,
    output logic [16:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout
);

    localparam int                c_slot_w    = $clog2(SLOT_DIV);
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(SLOT_DIV - 1);

    logic [c_slot_w-1:0] r_slot_cnt;
    arb_state_t          r_state;
    arb_grant_t          r_grant;
    logic                r_vid_last;

    logic                r_pend_valid;
    logic                r_pend_direct;
    logic                r_pend_we;
    shadow_entry_t       r_pend_entry;

    logic                w_slot_start;
    logic                w_accept;
    logic                w_direct;
    logic                w_shadow;
    logic                w_fifo_room;
    logic                w_shadow_blocked;
    logic                w_pend_push;
    logic                w_fifo_push;
    logic                w_fifo_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [24:0]         w_fifo_head_raw;
    shadow_entry_t       w_fifo_head;
    shadow_entry_t       w_cpu_entry;
    shadow_entry_t       w_push_entry;
    logic                w_vid_ok;
    logic                w_cpu_ok;
    arb_grant_t          w_grant;

    assign w_slot_start = (r_slot_cnt == '0);

    // A stalled CPU keeps its strobe asserted; only the first one is taken.
    assign w_accept    = cpu_stb && !r_pend_valid;
    assign w_direct    = w_accept && is_direct(cpu_bank);
    assign w_shadow    = w_accept && is_shadow(cpu_we, cpu_bank, cpu_addr, shadow_en);
    assign w_cpu_entry = '{a16: cpu_bank[0], addr: cpu_addr, data: cpu_wdata};

    assign w_fifo_pop       = (r_state == ISSUE) && (r_grant == GNT_FIFO);
    assign w_fifo_room      = !w_fifo_full || w_fifo_pop;
    assign w_shadow_blocked = w_shadow && !w_fifo_room;
    assign w_pend_push      = r_pend_valid && !r_pend_direct && w_fifo_room;
    assign w_fifo_push      = w_pend_push || (w_shadow && w_fifo_room);
    assign w_push_entry     = r_pend_valid ? r_pend_entry : w_cpu_entry;
    assign w_fifo_head      = w_fifo_head_raw;

    assign cpu_stall = w_direct || w_shadow_blocked || r_pend_valid;
    assign vid_data  = vid_ack    ? ram_dout : 8'h00;
    assign cpu_rdata = cpu_rvalid ? ram_dout : 8'h00;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (25)
    ) u_shadow_fifo (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .push      (w_fifo_push),
        .push_data (w_push_entry),
        .pop       (w_fifo_pop),
        .pop_data  (w_fifo_head_raw),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Video may not take back-to-back slots while the shadow buffer is full;
    // a direct read waits for the buffer so it observes every shadowed write.
    assign w_vid_ok = vid_req && !(r_vid_last && w_fifo_full);
    assign w_cpu_ok = r_pend_valid && r_pend_direct && (r_pend_we || w_fifo_empty);

    always_comb begin
        w_grant = GNT_NONE;
        if (w_vid_ok) begin
            w_grant = GNT_VID;
        end else if (w_fifo_full) begin
            w_grant = GNT_FIFO;
        end else if (w_cpu_ok) begin
            w_grant = GNT_CPU;
        end else if (!w_fifo_empty) begin
            w_grant = GNT_FIFO;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_cnt    <= '0;
            r_state       <= IDLE;
            r_grant       <= GNT_NONE;
            r_vid_last    <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_direct <= 1'b0;
            r_pend_we     <= 1'b0;
            r_pend_entry  <= '0;
            ram_ce        <= 1'b0;
            ram_wr        <= 1'b0;
            ram_addr      <= '0;
            ram_din       <= '0;
            vid_ack       <= 1'b0;
            cpu_rvalid    <= 1'b0;
        end else begin
            r_slot_cnt <= (r_slot_cnt == c_slot_last) ? '0 : r_slot_cnt + 1'b1;
            ram_ce     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            vid_ack    <= 1'b0;
            cpu_rvalid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_slot_start) begin
                        r_vid_last <= (w_grant == GNT_VID);
                        if (w_grant != GNT_NONE) begin
                            r_state <= ISSUE;
                            r_grant <= w_grant;
                            ram_ce  <= 1'b1;
                            case (w_grant)
                                GNT_VID: begin
                                    ram_addr <= vid_addr;
                                end
                                GNT_FIFO: begin
                                    ram_wr   <= 1'b1;
                                    ram_addr <= {w_fifo_head.a16, w_fifo_head.addr};
                                    ram_din  <= w_fifo_head.data;
                                end
                                default: begin
                                    ram_wr   <= r_pend_we;
                                    ram_addr <= {r_pend_entry.a16, r_pend_entry.addr};
                                    ram_din  <= r_pend_entry.data;
                                end
                            endcase
                        end
                    end
                end
                ISSUE: begin
                    r_state    <= CAPTURE;
                    vid_ack    <= (r_grant == GNT_VID);
                    cpu_rvalid <= (r_grant == GNT_CPU) && !r_pend_we;
                end
                CAPTURE: begin
                    r_state <= IDLE;
                    r_grant <= GNT_NONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= GNT_NONE;
                end
            endcase

            if (w_direct) begin
                r_pend_valid  <= 1'b1;
                r_pend_direct <= 1'b1;
                r_pend_we     <= cpu_we;
                r_pend_entry  <= w_cpu_entry;
            end else if (w_shadow_blocked) begin
                r_pend_valid  <= 1'b1;
                r_pend_direct <= 1'b0;
                r_pend_we     <= 1'b1;
                r_pend_entry  <= w_cpu_entry;
            end else if (w_pend_push) begin
                r_pend_valid  <= 1'b0;
            end else if ((r_state == CAPTURE) && (r_grant == GNT_CPU)) begin
                r_pend_valid  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_slowram_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_slowram_arbiter
// Brief  : Scoreboard bench for slowram_arbiter with a behavioural slow RAM.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_slowram_arbiter;

    localparam int SLOT_DIV   = 14;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk_sys   = 1'b0;
    logic        reset_n   = 1'b0;
    logic        cpu_stb   = 1'b0;
    logic        cpu_we    = 1'b0;
    logic [7:0]  cpu_bank  = 8'h00;
    logic [15:0] cpu_addr  = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        shadow_en = 1'b0;
    logic        cpu_stall;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        vid_req   = 1'b0;
    logic [16:0] vid_addr  = 17'h0;
    logic        vid_ack;
    logic [7:0]  vid_data;
    logic        ram_ce;
    logic        ram_wr;
    logic [16:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout  = 8'h00;

    logic [7:0]  mem [0:131071];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    wr_t         wr_q[$];
    logic [7:0]  rd_q[$];
    logic        grant_log[$];
    logic [7:0]  vid_exp = 8'h00;
    int          wrq_at_rvalid = -1;
    int          last_ce_cyc = 0;
    bit          mon_en = 1'b0;
    bit          log_en = 1'b0;
    wr_t         mon_e;

    slowram_arbiter #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SLOT_DIV   (SLOT_DIV)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .cpu_stb    (cpu_stb),
        .cpu_we     (cpu_we),
        .cpu_bank   (cpu_bank),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .shadow_en  (shadow_en),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_data   (vid_data),
        .ram_ce     (ram_ce),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (ram_ce) begin
            if (ram_wr) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every RAM write, read return and video return is matched here.
    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (ram_ce) begin
                if (log_en) grant_log.push_back(ram_wr);
                if (ram_wr) begin
                    if (wr_q.size() == 0) begin
                        chk("wr_unexpected_qsize", 64'(wr_q.size()), 64'd1);
                    end else begin
                        mon_e = wr_q.pop_front();
                        chk("wr_addr", 64'(ram_addr), 64'(mon_e.addr));
                        chk("wr_data", 64'(ram_din), 64'(mon_e.data));
                    end
                end
            end
            if (vid_ack) chk("vid_data", 64'(vid_data), 64'(vid_exp));
            if (cpu_rvalid) begin
                wrq_at_rvalid = wr_q.size();
                if (rd_q.size() == 0) chk("rd_unexpected_qsize", 64'(rd_q.size()), 64'd1);
                else                  chk("cpu_rdata", 64'(cpu_rdata), 64'(rd_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cpu_op(input logic we, input logic [7:0] bank, input logic [15:0] addr,
                          input logic [7:0] data, output logic stalled);
        cpu_stb   = 1'b1;
        cpu_we    = we;
        cpu_bank  = bank;
        cpu_addr  = addr;
        cpu_wdata = data;
        #1;
        stalled = cpu_stall;
        @(posedge clk_sys);
        #1;
        cpu_stb = 1'b0;
        for (int i = 0; i < 40 * SLOT_DIV && cpu_stall; i++) tick();
        chk("stall_release", 64'(cpu_stall), 64'd0);
    endtask

    task automatic shadow_wr(input logic [7:0] bank, input logic [15:0] addr,
                             input logic [7:0] data, output logic stalled);
        wr_q.push_back('{addr: {bank[0], addr}, data: data});
        cpu_op(1'b1, bank, addr, data, stalled);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 * SLOT_DIV && wr_q.size() != 0; i++) tick();
        chk("drain_qsize", 64'(wr_q.size()), 64'd0);
    endtask

    // Returns in the ack cycle, i.e. two cycles after a slot start.
    task automatic vid_fetch(input logic [16:0] a, input logic [7:0] d);
        int k;
        vid_addr = a;
        vid_exp  = d;
        vid_req  = 1'b1;
        for (k = 0; k < 3 * SLOT_DIV && !(ram_ce && !ram_wr); k++) tick();
        chk("vid_ce_seen", 64'(ram_ce && !ram_wr), 64'd1);
        chk("vid_ram_addr", 64'(ram_addr), 64'(a));
        chk("vid_ack_early", 64'(vid_ack), 64'd0);
        last_ce_cyc = cyc;
        tick();
        chk("vid_ack_t2", 64'(vid_ack), 64'd1);
        chk("vid_ce_one_cycle", 64'(ram_ce), 64'd0);
        vid_req = 1'b0;
    endtask

    logic st;
    int   ce1;

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        mem[17'h02000] = 8'h5A;
        mem[17'h1F000] = 8'hC3;
        mem[17'h00800] = 8'hEE;

        idle(3);
        chk("rst_outputs", 64'({cpu_stall, cpu_rvalid, vid_ack, ram_ce, ram_wr, ram_addr,
                                ram_din, cpu_rdata, vid_data}), 64'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(2);

        // Video fetch: ce then ack one cycle later; consecutive requests one slot apart.
        vid_fetch(17'h02000, 8'h5A);
        ce1 = last_ce_cyc;
        vid_fetch(17'h02000, 8'h5A);
        chk("slot_period", 64'(last_ce_cyc - ce1), 64'(SLOT_DIV));

        // Shadow qualification.
        shadow_en = 1'b1;
        shadow_wr(8'h00, 16'h0400, 8'hA5, st);
        chk("t3_no_stall", 64'(st), 64'd0);
        wait_drain();
        shadow_en = 1'b0;
        cpu_op(1'b1, 8'h00, 16'h0500, 8'h01, st);
        shadow_en = 1'b1;
        cpu_op(1'b1, 8'h00, 16'hC000, 8'h02, st);
        cpu_op(1'b1, 8'h01, 16'h03FF, 8'h03, st);
        cpu_op(1'b1, 8'h02, 16'h0400, 8'h04, st);
        cpu_op(1'b0, 8'h00, 16'h0400, 8'h05, st);
        chk("t3_ignored_no_stall", 64'(st), 64'd0);
        idle(2 * SLOT_DIV + 4);

        // Five back-to-back shadow writes into a 4-deep buffer.
        vid_fetch(17'h02000, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            shadow_wr((i % 2 == 0) ? 8'h00 : 8'h01, 16'h1000 + 16'(i), 8'h10 + 8'(i), st);
            chk("t4_stall", 64'(st), 64'(i == 4));
            if (i == 4) chk("t4_release_after_first_pop", 64'(wr_q.size()), 64'd4);
        end
        wait_drain();

        // Direct read after buffered shadow write sees the new data.
        vid_fetch(17'h02000, 8'h5A);
        wrq_at_rvalid = -1;
        shadow_wr(8'h00, 16'h0800, 8'h11, st);
        chk("t5_shadow_no_stall", 64'(st), 64'd0);
        rd_q.push_back(8'h11);
        cpu_op(1'b0, 8'hE0, 16'h0800, 8'h00, st);
        chk("t5_direct_stall", 64'(st), 64'd1);
        chk("t5_rvalid_seen", 64'(rd_q.size()), 64'd0);
        chk("t5_fifo_empty_at_read", 64'(wrq_at_rvalid), 64'd0);
        wr_q.push_back('{addr: 17'h13000, data: 8'h77});
        cpu_op(1'b1, 8'hE1, 16'h3000, 8'h77, st);
        chk("t5_direct_wr_stall", 64'(st), 64'd1);
        chk("t5_direct_wr_done", 64'(wr_q.size()), 64'd0);
        rd_q.push_back(8'h77);
        cpu_op(1'b0, 8'hE1, 16'h3000, 8'h00, st);
        chk("t5_readback_seen", 64'(rd_q.size()), 64'd0);

        // Constant video demand against a full buffer: slots alternate while full.
        vid_fetch(17'h1F000, 8'hC3);
        grant_log.delete();
        log_en  = 1'b1;
        vid_req = 1'b1;
        for (int i = 0; i < 8; i++) shadow_wr(8'h00, 16'h2000 + 16'(i), 8'h40 + 8'(i), st);
        for (int i = 0; i < 20 * SLOT_DIV && wr_q.size() > 3; i++) tick();
        idle(2 * SLOT_DIV);
        log_en = 1'b0;
        chk("t6_log_len", 64'(grant_log.size() >= 11), 64'd1);
        for (int i = 0; i < 11 && i < grant_log.size(); i++) begin
            chk("t6_slot_owner", 64'(grant_log[i]), 64'((i < 9) && (i % 2 == 0)));
        end
        vid_req = 1'b0;
        wait_drain();

        // Reset in the middle of a write issue abandons it and empties the buffer.
        vid_fetch(17'h02000, 8'h5A);
        mon_en = 1'b0;
        cpu_op(1'b1, 8'h00, 16'h3000, 8'hAA, st);
        cpu_op(1'b1, 8'h00, 16'h3001, 8'hBB, st);
        for (int i = 0; i < 3 * SLOT_DIV && !(ram_ce && ram_wr); i++) tick();
        chk("t1_in_issue", 64'(ram_ce && ram_wr), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t1_rst_ce", 64'(ram_ce), 64'd0);
        chk("t1_rst_outputs", 64'({cpu_stall, cpu_rvalid, vid_ack, ram_ce, ram_wr, ram_addr,
                                   ram_din, cpu_rdata, vid_data}), 64'd0);
        tick();
        chk("t1_rst_hold", 64'({ram_ce, ram_wr, ram_addr, ram_din}), 64'd0);
        reset_n = 1'b1;
        wr_q.delete();
        mon_en = 1'b1;
        idle(3 * SLOT_DIV);
        chk("t1_no_stall", 64'(cpu_stall), 64'd0);
        shadow_wr(8'h01, 16'hBFFF, 8'h5C, st);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1);
    end

endmodule

`default_nettype wire
